// File: rtl/ds1302_burst_ctrler.sv
// ds1302_burst_ctrler: DS1302 3-wire master for single-byte and 1..MAX_BYTES burst transfers.
// Command and data go LSB first; write bytes are streamed in on wr_req, read bytes out on rd_valid.
module ds1302_burst_ctrler #(
    parameter int SCLK_FREQ        = 50_000_000,
    parameter int DS1302_CLK_SPEED = 500_000,
    parameter int CE_GUARD_CYC     = 200,
    parameter int MAX_BYTES        = 31
) (
    input  logic       sclk,
    input  logic       nrst,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] cmd_addr,
    input  logic [5:0] byte_count,
    input  logic [7:0] wr_data,
    output logic       wr_req,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       ds1302_ce,
    output logic       ds1302_sclk,
    inout  wire        ds1302_io
);
    localparam int HALF = SCLK_FREQ / (2 * DS1302_CLK_SPEED);
    localparam int CMAX = CE_GUARD_CYC > 2 * HALF ? CE_GUARD_CYC : 2 * HALF;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CE_SETUP = 3'd1;
    localparam logic [2:0] CMD      = 3'd2;
    localparam logic [2:0] WR_DATA  = 3'd3;
    localparam logic [2:0] RD_DATA  = 3'd4;
    localparam logic [2:0] CE_HOLD  = 3'd5;
    localparam logic [2:0] GAP      = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [5:0]    byte_cnt, n, n_in;
    logic [7:0]    sr, wd0;
    logic          rw_q, oe, io_q;
    logic          guard_end, drive_pt, rise_pt, bit_end, byte_end, last_byte, xfer;

    assign guard_end = cnt == CW'(CE_GUARD_CYC - 1);
    assign drive_pt  = cnt == CW'(HALF / 2);
    assign rise_pt   = cnt == CW'(HALF - 1);
    assign bit_end   = cnt == CW'(2 * HALF - 1);
    assign byte_end  = bit_end && bit_cnt == 3'd7;
    assign last_byte = byte_cnt + 6'd1 == n;
    assign xfer      = state == CMD || state == WR_DATA || state == RD_DATA;
    assign busy      = state != IDLE;
    assign n_in      = byte_count == 6'd0 ? 6'd1 : byte_count > 6'(MAX_BYTES) ? 6'(MAX_BYTES) : byte_count;
    assign ds1302_io = oe ? io_q : 1'bz;

    // cnt is the guard timer in CE_SETUP/CE_HOLD/GAP and the bit-phase counter while clocking
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            n           <= '0;
            sr          <= '0;
            wd0         <= '0;
            rw_q        <= 1'b0;
            oe          <= 1'b0;
            io_q        <= 1'b0;
            ds1302_ce   <= 1'b0;
            ds1302_sclk <= 1'b0;
            wr_req      <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            done        <= 1'b0;
        end else begin
            wr_req   <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            cnt      <= cnt + CW'(1);
            if (xfer && rise_pt) ds1302_sclk <= 1'b1;
            if (xfer && bit_end) begin
                ds1302_sclk <= 1'b0;
                cnt         <= '0;
                bit_cnt     <= bit_cnt + 3'd1;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state     <= CE_SETUP;
                        ds1302_ce <= 1'b1;
                        rw_q      <= rw;
                        sr        <= (cmd_addr & 8'hFE) | {7'd0, rw};
                        wd0       <= wr_data;
                        n         <= n_in;
                        bit_cnt   <= '0;
                        byte_cnt  <= '0;
                    end
                end
                CE_SETUP: if (guard_end) begin
                    state <= CMD;
                    cnt   <= '0;
                end
                CMD: begin
                    if (drive_pt) begin
                        oe   <= 1'b1;
                        io_q <= sr[0];
                    end
                    if (bit_end) sr <= {1'b0, sr[7:1]};
                    if (byte_end) begin
                        state  <= rw_q ? RD_DATA : WR_DATA;
                        oe     <= !rw_q;
                        sr     <= wd0;
                        wr_req <= !rw_q && n > 6'd1;
                    end
                end
                WR_DATA: begin
                    if (drive_pt) io_q <= sr[0];
                    if (bit_end) sr <= {1'b0, sr[7:1]};
                    if (byte_end) begin
                        byte_cnt <= byte_cnt + 6'd1;
                        state    <= last_byte ? CE_HOLD : WR_DATA;
                        oe       <= !last_byte;
                        sr       <= wr_data;
                        wr_req   <= !last_byte && byte_cnt + 6'd2 < n;
                    end
                end
                RD_DATA: begin
                    if (rise_pt) sr <= {ds1302_io, sr[7:1]};
                    if (rise_pt && bit_cnt == 3'd7) begin
                        rd_data  <= {ds1302_io, sr[7:1]};
                        rd_valid <= 1'b1;
                    end
                    if (byte_end) begin
                        byte_cnt <= byte_cnt + 6'd1;
                        if (last_byte) state <= CE_HOLD;
                    end
                end
                CE_HOLD: if (guard_end) begin
                    state     <= GAP;
                    cnt       <= '0;
                    ds1302_ce <= 1'b0;
                    done      <= 1'b1;
                end
                GAP: if (guard_end) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
